csr_ctrl: RTL and testbench
===========================

Name: csr_ctrl

Overview:
- Multi-cycle sequencer that sits between the NPC execute stage and the machine-mode CSR register file.
- Accepts one CSR-class instruction per handshake: CSRRW/RS/RC (register or immediate operand already muxed by the decoder), ECALL or MRET.
- Drives the CSR file's address, write data, write enable and exception strobe.
- Returns the rd value and any PC redirect to the core.

Parameters:
- XLEN, 32, datapath width for CSR data, PC and cause.
- ADDR_W, 12, CSR address width; zero-extended to 32 on csr_addr.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  1  instruction offered
- req_ready  out  1  controller idle, can accept
- req_op  in  3  0=RW 1=RS 2=RC 3=ECALL 4=MRET; 5-7 reserved
- req_addr  in  ADDR_W  CSR address from instruction
- req_src  in  XLEN  rs1 value or zero-extended zimm
- req_nowr  in  1  rs1/zimm field is x0/0; suppresses write for RS/RC
- req_pc  in  XLEN  PC of instruction
- resp_valid  out  1  result available
- resp_ready  in  1  core consumes result
- resp_rdata  out  XLEN  old CSR value for rd (0 for ECALL/MRET)
- resp_rd_wen  out  1  write rd
- resp_redirect  out  1  PC must be replaced
- resp_pc  out  XLEN  redirect target
- csr_addr  out  32  to CSR file addr
- csr_wdata  out  XLEN  to CSR file csr_in
- csr_wen  out  1  to CSR file
- csr_exc  out  1  to CSR file exception
- csr_exc_pc  out  XLEN  to CSR file exception_pc
- csr_exc_cause  out  XLEN  to CSR file exception_cause
- csr_rdata  in  XLEN  CSR file csr_out (combinational on csr_addr)
- csr_mtvec  in  XLEN  CSR file mtvec
- csr_mepc  in  XLEN  CSR file mepc

Behaviour:
- States: IDLE, READ, WRITE, TRAP, RESP. Reset forces IDLE; all registered outputs 0, including csr_addr.
- req_ready=1 only in IDLE. On accept, op/addr/src/nowr/pc are latched.
- Reserved op is treated as RW.
- RW/RS/RC path:
  - IDLE->READ: csr_addr holds the latched address; csr_rdata is captured into an old-value register at end of READ.
  - READ->WRITE: new value is src for RW, old|src for RS, old&~src for RC.
  - csr_wen pulses for exactly one cycle in WRITE, except RS/RC with nowr=1, where csr_wen stays 0 (RW always writes).
  - WRITE->RESP: resp_rdata=old, resp_rd_wen=1, resp_redirect=0.
  - Latency: accept at cycle 0, resp_valid at cycle 3.
- ECALL path:
  - IDLE->TRAP: csr_exc=1 for exactly one cycle, csr_exc_pc=latched pc, csr_exc_cause=11.
  - csr_mtvec is sampled in TRAP.
  - TRAP->RESP: resp_redirect=1, resp_pc=mtvec, resp_rd_wen=0.
  - Latency 2.
- MRET path:
  - IDLE->RESP: csr_mepc is sampled on accept; resp_redirect=1, resp_pc=mepc, resp_rd_wen=0.
  - Latency 1.
- RESP handshake:
  - Outputs are held stable until resp_ready; RESP->IDLE on resp_valid&&resp_ready.
  - No new accept in the same cycle (req_ready=0 during RESP).
- csr_wen and csr_exc are never asserted together.
- csr_wen and csr_exc are 0 in IDLE and RESP.
- Back-to-back writes to the same CSR: the second read observes the first write, because the write commits before RESP.
- rst mid-operation: immediate return to IDLE, pending write/trap discarded, no partial strobes after rst deasserts.

Optional Feature:
- CSR_ILLEGAL_EN defined:
  - RW/RS/RC to an address outside {0x300,0x305,0x341,0x342} goes IDLE->TRAP with cause 2 and exc_pc=pc.
  - No csr_wen is issued; resp_rd_wen=0, redirect to mtvec.
- Undefined: unimplemented addresses read 0 (CSR file default) and writes are issued but ignored by the file.

Decomposition:
- Package csr_ctrl_pkg holds:
  - op encodings
  - state enum
  - CSR address constants (MSTATUS 0x300, MTVEC 0x305, MEPC 0x341, MCAUSE 0x342)
  - cause constants (ECALL_M=11, ILLEGAL=2)
- One combinational sub-module csr_wdata_alu(op, old, src) -> new value.

Test Plan:
- CSRRW 0x305 src=0x80000100, CSR held 0 -> csr_wen at cycle 2 with wdata 0x80000100; resp at cycle 3 with rdata 0, rd_wen=1.
- CSRRS 0x300 src=0x8, mstatus=0x1800 -> wdata 0x1808, rdata 0x1800. Repeat with nowr=1 -> no csr_wen, rdata 0x1808.
- CSRRC 0x300 src=0x1000 after above -> wdata 0x0808. Hold resp_ready=0 for 4 cycles -> outputs stable, req_ready=0.
- ECALL pc=0x80000040, mtvec=0x80000100 -> csr_exc one cycle with cause 11, pc 0x80000040; resp redirect to 0x80000100 at cycle 2.
- MRET with mepc=0x80000044 -> resp at cycle 1, redirect 0x80000044, no csr_wen/csr_exc.
- Assert rst during WRITE of CSRRW -> no csr_wen observed; after release req_ready=1 and the CSR is unchanged. With CSR_ILLEGAL_EN, CSRRW 0x7C0 -> cause 2 trap, no csr_wen.

Source files
------------

// File: rtl/csr_ctrl_pkg.sv
// Shared encodings for the CSR sequencer: ops, FSM states, CSR addresses and trap causes.
package csr_ctrl_pkg;

    typedef enum logic [2:0] {
        OP_RW    = 3'd0,
        OP_RS    = 3'd1,
        OP_RC    = 3'd2,
        OP_ECALL = 3'd3,
        OP_MRET  = 3'd4
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WRITE,
        S_TRAP,
        S_RESP
    } state_e;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;

    localparam int unsigned CAUSE_ECALL_M = 11;
    localparam int unsigned CAUSE_ILLEGAL = 2;

    // Reserved encodings collapse onto RW so the datapath only ever sees five ops.
    function automatic op_e norm_op(input logic [2:0] op);
        return (op > 3'd4) ? OP_RW : op_e'(op);
    endfunction

    function automatic logic csr_is_impl(input logic [31:0] a);
        return (a == 32'(CSR_MSTATUS)) || (a == 32'(CSR_MTVEC)) ||
               (a == 32'(CSR_MEPC))    || (a == 32'(CSR_MCAUSE));
    endfunction

    function automatic logic [31:0] trap_cause(input logic illegal);
        return illegal ? 32'(CAUSE_ILLEGAL) : 32'(CAUSE_ECALL_M);
    endfunction

endpackage

// File: rtl/csr_wdata_alu.sv
// New CSR value for CSRRW/RS/RC from the old value and the operand.
module csr_wdata_alu
    import csr_ctrl_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  op_e             op,
    input  logic [XLEN-1:0] old,
    input  logic [XLEN-1:0] src,
    output logic [XLEN-1:0] wdata
);

    always_comb begin
        wdata = src;
        case (op)
            OP_RS:   wdata = old | src;
            OP_RC:   wdata = old & ~src;
            default: wdata = src;
        endcase
    end

endmodule

// File: rtl/csr_ctrl.sv
// CSR instruction sequencer between execute and the machine-mode CSR file.
// Optional: define CSR_ILLEGAL_EN to trap (cause 2) on accesses to unimplemented CSRs.
module csr_ctrl
    import csr_ctrl_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [XLEN-1:0]   req_src,
    input  logic              req_nowr,
    input  logic [XLEN-1:0]   req_pc,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [XLEN-1:0]   resp_rdata,
    output logic              resp_rd_wen,
    output logic              resp_redirect,
    output logic [XLEN-1:0]   resp_pc,
    output logic [31:0]       csr_addr,
    output logic [XLEN-1:0]   csr_wdata,
    output logic              csr_wen,
    output logic              csr_exc,
    output logic [XLEN-1:0]   csr_exc_pc,
    output logic [XLEN-1:0]   csr_exc_cause,
    input  logic [XLEN-1:0]   csr_rdata,
    input  logic [XLEN-1:0]   csr_mtvec,
    input  logic [XLEN-1:0]   csr_mepc
);

    typedef struct packed {
        op_e               op;
        logic [ADDR_W-1:0] addr;
        logic [XLEN-1:0]   src;
        logic              nowr;
        logic [XLEN-1:0]   pc;
    } req_t;

    state_e          state, state_nx;
    req_t            q;
    logic [XLEN-1:0] old_q;
    logic [XLEN-1:0] rpc_q;
    logic [XLEN-1:0] cause_q;
    logic            rd_wen_q;
    logic            redirect_q;

    op_e  op_in;
    logic is_rw_in;
    logic illegal_in;
    logic accept;

    assign op_in    = norm_op(req_op);
    assign is_rw_in = (op_in != OP_ECALL) && (op_in != OP_MRET);
    assign accept   = req_valid && req_ready;

`ifdef CSR_ILLEGAL_EN
    assign illegal_in = is_rw_in && !csr_is_impl(32'(req_addr));
`else
    assign illegal_in = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (req_valid) begin
                    if (op_in == OP_MRET)                      state_nx = S_RESP;
                    else if (op_in == OP_ECALL || illegal_in) state_nx = S_TRAP;
                    else                                       state_nx = S_READ;
                end
            end
            S_READ:  state_nx = S_WRITE;
            S_WRITE: state_nx = S_RESP;
            S_TRAP:  state_nx = S_RESP;
            S_RESP:  if (resp_ready) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready     = (state == S_IDLE);
        resp_valid    = (state == S_RESP);
        // nowr only suppresses the write for the set/clear forms
        csr_wen       = (state == S_WRITE) && ((q.op == OP_RW) || !q.nowr);
        csr_exc       = (state == S_TRAP);
        resp_rd_wen   = (state == S_RESP) && rd_wen_q;
        resp_redirect = (state == S_RESP) && redirect_q;
        resp_rdata    = resp_rd_wen ? old_q : '0;
        resp_pc       = resp_redirect ? rpc_q : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q          <= '0;
            old_q      <= '0;
            rpc_q      <= '0;
            cause_q    <= '0;
            rd_wen_q   <= 1'b0;
            redirect_q <= 1'b0;
        end else begin
            if (accept) begin
                q          <= '{op: op_in, addr: req_addr, src: req_src,
                                nowr: req_nowr, pc: req_pc};
                cause_q    <= XLEN'(trap_cause(illegal_in));
                rd_wen_q   <= is_rw_in && !illegal_in;
                redirect_q <= !(is_rw_in && !illegal_in);
                if (op_in == OP_MRET) rpc_q <= csr_mepc;
            end
            if (state == S_READ) old_q <= csr_rdata;
            if (state == S_TRAP) rpc_q <= csr_mtvec;
        end
    end

    assign csr_addr      = 32'(q.addr);
    assign csr_exc_pc    = q.pc;
    assign csr_exc_cause = cause_q;

    csr_wdata_alu #(.XLEN(XLEN)) u_alu (
        .op    (q.op),
        .old   (old_q),
        .src   (q.src),
        .wdata (csr_wdata)
    );

endmodule

// File: tb/tb_csr_ctrl.sv
// Directed vector bench for csr_ctrl with a small behavioural CSR file attached.
module tb_csr_ctrl;
    import csr_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_nowr;
    logic [2:0]  req_op;
    logic [11:0] req_addr;
    logic [31:0] req_src, req_pc;
    logic        resp_valid, resp_ready, resp_rd_wen, resp_redirect;
    logic [31:0] resp_rdata, resp_pc;
    logic [31:0] csr_addr, csr_wdata, csr_exc_pc, csr_exc_cause;
    logic        csr_wen, csr_exc;
    logic [31:0] csr_rdata, csr_mtvec, csr_mepc;

    always #5 clk = ~clk;

    csr_ctrl #(.XLEN(32), .ADDR_W(12)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_addr(req_addr), .req_src(req_src), .req_nowr(req_nowr), .req_pc(req_pc),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
        .resp_rd_wen(resp_rd_wen), .resp_redirect(resp_redirect), .resp_pc(resp_pc),
        .csr_addr(csr_addr), .csr_wdata(csr_wdata), .csr_wen(csr_wen), .csr_exc(csr_exc),
        .csr_exc_pc(csr_exc_pc), .csr_exc_cause(csr_exc_cause),
        .csr_rdata(csr_rdata), .csr_mtvec(csr_mtvec), .csr_mepc(csr_mepc)
    );

    // Behavioural CSR file: combinational read, commit on the clock edge.
    logic [31:0] f_mstatus, f_mtvec, f_mepc, f_mcause;
    int          wr_cnt;
    logic        file_init;

    always_comb begin
        csr_rdata = '0;
        case (csr_addr)
            32'h300: csr_rdata = f_mstatus;
            32'h305: csr_rdata = f_mtvec;
            32'h341: csr_rdata = f_mepc;
            32'h342: csr_rdata = f_mcause;
            default: csr_rdata = '0;
        endcase
    end
    assign csr_mtvec = f_mtvec;
    assign csr_mepc  = f_mepc;

    always @(posedge clk) begin
        if (file_init) begin
            f_mstatus <= 32'h1800;
            f_mtvec   <= '0;
            f_mepc    <= '0;
            f_mcause  <= '0;
            wr_cnt    <= 0;
        end else if (csr_wen) begin
            wr_cnt <= wr_cnt + 1;
            case (csr_addr)
                32'h300: f_mstatus <= csr_wdata;
                32'h305: f_mtvec   <= csr_wdata;
                32'h341: f_mepc    <= csr_wdata;
                32'h342: f_mcause  <= csr_wdata;
                default: ;
            endcase
        end else if (csr_exc) begin
            f_mepc   <= csr_exc_pc;
            f_mcause <= csr_exc_cause;
        end
    end

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [11:0] addr;
        logic [31:0] src;
        logic        nowr;
        logic [31:0] pc;
        int          hold;
        int          lat;
        logic        wen;
        logic [31:0] wdata;
        logic        exc;
        logic [31:0] cause;
        logic [31:0] rdata;
        logic        rd_wen;
        logic        redirect;
        logic [31:0] rpc;
    } vec_t;

    task automatic run_vec(input vec_t v);
        int lat = -1, wen_n = 0, exc_n = 0, both = 0, wcyc = 0, ecyc = 0;
        logic [31:0] wd = '0, ec = '0, epc = '0;
        @(negedge clk);
        chk({v.name, "/req_ready"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_op = v.op; req_addr = v.addr;
        req_src = v.src; req_nowr = v.nowr; req_pc = v.pc;
        for (int cyc = 1; cyc <= 10; cyc++) begin
            @(negedge clk);
            req_valid = 1'b0;
            if (csr_wen && csr_exc) both++;
            if (csr_wen) begin wen_n++; wd = csr_wdata; wcyc = cyc; end
            if (csr_exc) begin exc_n++; ec = csr_exc_cause; epc = csr_exc_pc; ecyc = cyc; end
            if (resp_valid) begin lat = cyc; break; end
        end
        chk({v.name, "/latency"}, 32'(lat), 32'(v.lat));
        chk({v.name, "/wen_pulses"}, 32'(wen_n), 32'(v.wen));
        if (v.wen) begin
            chk({v.name, "/wdata"}, wd, v.wdata);
            chk({v.name, "/wen_cycle"}, 32'(wcyc), 32'd2);
        end
        chk({v.name, "/exc_pulses"}, 32'(exc_n), 32'(v.exc));
        if (v.exc) begin
            chk({v.name, "/exc_cause"}, ec, v.cause);
            chk({v.name, "/exc_pc"}, epc, v.pc);
            chk({v.name, "/exc_cycle"}, 32'(ecyc), 32'd1);
        end
        chk({v.name, "/wen_exc_overlap"}, 32'(both), 32'd0);
        chk({v.name, "/rdata"}, resp_rdata, v.rdata);
        chk({v.name, "/rd_wen"}, 32'(resp_rd_wen), 32'(v.rd_wen));
        chk({v.name, "/redirect"}, 32'(resp_redirect), 32'(v.redirect));
        if (v.redirect) chk({v.name, "/resp_pc"}, resp_pc, v.rpc);
        for (int h = 0; h < v.hold; h++) begin
            @(negedge clk);
            chk({v.name, "/hold_valid"}, 32'(resp_valid), 32'd1);
            chk({v.name, "/hold_req_ready"}, 32'(req_ready), 32'd0);
            chk({v.name, "/hold_rdata"}, resp_rdata, v.rdata);
            chk({v.name, "/hold_strobes"}, {30'd0, csr_wen, csr_exc}, 32'd0);
            if (v.redirect) chk({v.name, "/hold_pc"}, resp_pc, v.rpc);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        chk({v.name, "/resp_done"}, 32'(resp_valid), 32'd0);
        chk({v.name, "/back_idle"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vq[$];
        int   wr_before;

        rst = 1'b1; file_init = 1'b1;
        req_valid = 1'b0; req_op = '0; req_addr = '0; req_src = '0;
        req_nowr = 1'b0; req_pc = '0; resp_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset/req_ready", 32'(req_ready), 32'd1);
        chk("reset/resp_valid", 32'(resp_valid), 32'd0);
        chk("reset/strobes", {30'd0, csr_wen, csr_exc}, 32'd0);
        chk("reset/csr_addr", csr_addr, 32'd0);
        rst = 1'b0; file_init = 1'b0;

        //           name          op    addr     src           nowr  pc            hold lat wen wdata         exc cause  rdata         rdw redir rpc
        vq.push_back('{"rw_mtvec",   3'd0, 12'h305, 32'h80000100, 1'b0, 32'h80000000, 0, 3, 1'b1, 32'h80000100, 1'b0, 32'd0, 32'h0,        1'b1, 1'b0, 32'h0});
        vq.push_back('{"rs_mstatus", 3'd1, 12'h300, 32'h8,        1'b0, 32'h80000004, 0, 3, 1'b1, 32'h1808,     1'b0, 32'd0, 32'h1800,     1'b1, 1'b0, 32'h0});
        vq.push_back('{"rs_nowr",    3'd1, 12'h300, 32'h8,        1'b1, 32'h80000008, 0, 3, 1'b0, 32'h0,        1'b0, 32'd0, 32'h1808,     1'b1, 1'b0, 32'h0});
        vq.push_back('{"rc_hold",    3'd2, 12'h300, 32'h1000,     1'b0, 32'h8000000c, 4, 3, 1'b1, 32'h0808,     1'b0, 32'd0, 32'h1808,     1'b1, 1'b0, 32'h0});
        vq.push_back('{"ecall",      3'd3, 12'h000, 32'h0,        1'b0, 32'h80000040, 0, 2, 1'b0, 32'h0,        1'b1, 32'd11, 32'h0,       1'b0, 1'b1, 32'h80000100});
        vq.push_back('{"rw_mepc",    3'd0, 12'h341, 32'h80000044, 1'b0, 32'h80000104, 0, 3, 1'b1, 32'h80000044, 1'b0, 32'd0, 32'h80000040, 1'b1, 1'b0, 32'h0});
        vq.push_back('{"mret",       3'd4, 12'h000, 32'h0,        1'b0, 32'h80000108, 1, 1, 1'b0, 32'h0,        1'b0, 32'd0, 32'h0,        1'b0, 1'b1, 32'h80000044});
        vq.push_back('{"rsvd_as_rw", 3'd7, 12'h342, 32'h5,        1'b1, 32'h80000048, 0, 3, 1'b1, 32'h5,        1'b0, 32'd0, 32'd11,       1'b1, 1'b0, 32'h0});
        vq.push_back('{"rc_nowr",    3'd2, 12'h342, 32'hffff,     1'b1, 32'h8000004c, 0, 3, 1'b0, 32'h0,        1'b0, 32'd0, 32'h5,        1'b1, 1'b0, 32'h0});
`ifdef CSR_ILLEGAL_EN
        vq.push_back('{"illegal",    3'd0, 12'h7c0, 32'h1234,     1'b0, 32'h80000080, 0, 2, 1'b0, 32'h0,        1'b1, 32'd2,  32'h0,       1'b0, 1'b1, 32'h80000100});
`else
        vq.push_back('{"unimpl_rw",  3'd0, 12'h7c0, 32'h1234,     1'b0, 32'h80000080, 0, 3, 1'b1, 32'h1234,     1'b0, 32'd0, 32'h0,        1'b1, 1'b0, 32'h0});
`endif
        foreach (vq[i]) run_vec(vq[i]);

        // Reset in the middle of WRITE must drop the strobe before the commit edge.
        wr_before = wr_cnt;
        @(negedge clk);
        req_valid = 1'b1; req_op = 3'd0; req_addr = 12'h300; req_src = 32'hdead; req_nowr = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        chk("rst_mid/wen_before", 32'(csr_wen), 32'd1);
        #1 rst = 1'b1;
        #1 chk("rst_mid/wen_dropped", 32'(csr_wen), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid/req_ready", 32'(req_ready), 32'd1);
        chk("rst_mid/strobes", {30'd0, csr_wen, csr_exc}, 32'd0);
        chk("rst_mid/resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_mid/csr_addr", csr_addr, 32'd0);
        chk("rst_mid/no_commit", 32'(wr_cnt), 32'(wr_before));
        chk("rst_mid/mstatus", f_mstatus, 32'h0808);
        run_vec('{"rs_after_rst", 3'd1, 12'h300, 32'h0, 1'b1, 32'h80000200, 0, 3, 1'b0, 32'h0,
                  1'b0, 32'd0, 32'h0808, 1'b1, 1'b0, 32'h0});

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
